trng_req_arbiter: RTL and testbench

- Sits downstream of the TRNG sequencing FSM and bit datapath.
- Discards warm-up bits after RUN is entered, then packs qualified TRNG bits into words and buffers them in a small FIFO.
- Shares the word stream between NREQ requesters using round-robin arbitration.
- Sequences reseeds by pulsing a restart to the TRNG FSM and flushing all buffered entropy.

---
 rtl/trng_req_arbiter_pkg.sv | 30 +++
 rtl/trng_req_arbiter_if.sv | 17 +
 rtl/trng_req_arbiter_fifo.sv | 60 ++++++
 rtl/trng_req_arbiter.sv | 171 +++++++++++++++++
 tb/tb_trng_req_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trng_req_arbiter_pkg.sv
// Shared types and helpers for the TRNG word arbiter: FSM states, default
// sizing and the round-robin pick function.
package trng_pkg;

  typedef enum logic [1:0] {IDLE, DISCARD, FILL, RESEED} state_t;

  localparam int MAX_NREQ       = 8;
  localparam int DEF_NREQ       = 4;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_DISCARD    = 64;

  // One-hot pick of the first asserted req at or after (ptr+1) mod n, wrapping
  // so that ptr itself is considered last.
  function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                                  input logic [2:0]          ptr,
                                                  input int                  n);
    logic [MAX_NREQ-1:0] pick;
    int idx;
    pick = '0;
    for (int k = 1; k <= MAX_NREQ; k++) begin
      if (k <= n) begin
        idx = (int'(ptr) + k) % n;
        if (pick == '0 && req[idx[2:0]]) pick[idx[2:0]] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/trng_req_arbiter_if.sv
// Requester-side bus of the TRNG word arbiter: request vector, one-hot grant
// pulse and the word delivered with that grant.
interface trng_req_arbiter_if
  import trng_pkg::*;
#(
  parameter int NREQ   = DEF_NREQ,
  parameter int WORD_W = DEF_WORD_W
);

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic [WORD_W-1:0] rdata;

  modport master (output req, input gnt, input rdata);
  modport slave  (input req, output gnt, output rdata);

endinterface

// File: rtl/trng_req_arbiter_fifo.sv
// Single-clock word FIFO with flush; head is presented combinationally and a
// push into a full FIFO is accepted when a pop happens in the same cycle.
module trng_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign rdata   = mem[rd_q];
  assign level   = level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is data only; pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= wdata;
  end

endmodule

// File: rtl/trng_req_arbiter.sv
// Packs qualified TRNG bits into words after a warm-up discard, buffers them
// and hands them out round-robin; a reseed restarts the TRNG and flushes all.
module trng_req_arbiter
  import trng_pkg::state_t, trng_pkg::rr_pick;
#(
  parameter int NREQ       = trng_pkg::DEF_NREQ,
  parameter int WORD_W     = trng_pkg::DEF_WORD_W,
  parameter int FIFO_DEPTH = trng_pkg::DEF_FIFO_DEPTH,
  parameter int DISCARD    = trng_pkg::DEF_DISCARD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trng_run,
  input  logic                        trng_bit_valid,
  input  logic                        trng_bit,
  input  logic                        reseed_req,
  trng_req_arbiter_if.slave           bus,
  output logic                        trng_restart,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  overflow_cnt
);

  localparam int BCW = $clog2(WORD_W);
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]        disc_cnt_q, disc_cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              restart_q, restart_d;
  logic [7:0]        ovf_q, ovf_d;

  logic              qual;
  logic              push, pop, flush;
  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_head;
  logic [7:0]        req_ext;
  logic [7:0]        pick;
  logic [PW-1:0]     gidx;

  trng_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (shreg_d),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign qual         = trng_run & trng_bit_valid;
  assign bus.gnt      = gnt_q;
  assign bus.rdata    = rdata_q;
  assign trng_restart = restart_q;
  assign overflow_cnt = ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= trng_pkg::IDLE;
      bit_cnt_q  <= '0;
      disc_cnt_q <= '0;
      shreg_q    <= '0;
      rr_q       <= '0;
      gnt_q      <= '0;
      rdata_q    <= '0;
      restart_q  <= 1'b0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      shreg_q    <= shreg_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      rdata_q    <= rdata_d;
      restart_q  <= restart_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    disc_cnt_d = disc_cnt_q;
    shreg_d    = shreg_q;
    rr_d       = rr_q;
    gnt_d      = '0;
    rdata_d    = '0;
    restart_d  = 1'b0;
    ovf_d      = ovf_q;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;

    req_ext             = '0;
    req_ext[NREQ-1:0]   = bus.req;
    pick                = rr_pick(req_ext, 3'(rr_q), NREQ);
    gidx                = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) gidx = PW'(i);
    end

    // Reseed overrides everything, including a grant that would otherwise issue.
    if (reseed_req && state_q != trng_pkg::RESEED) begin
      state_d    = trng_pkg::RESEED;
      restart_d  = 1'b1;
      flush      = 1'b1;
      bit_cnt_d  = '0;
      disc_cnt_d = '0;
      shreg_d    = '0;
    end else begin
      unique case (state_q)
        trng_pkg::IDLE: begin
          if (trng_run) begin
            state_d    = trng_pkg::DISCARD;
            disc_cnt_d = '0;
          end
        end
        trng_pkg::DISCARD: begin
          if (!trng_run) begin
            state_d    = trng_pkg::IDLE;
            disc_cnt_d = '0;
          end else if (qual) begin
            if (disc_cnt_q == 8'(DISCARD - 1)) begin
              state_d    = trng_pkg::FILL;
              disc_cnt_d = '0;
            end else begin
              disc_cnt_d = disc_cnt_q + 8'd1;
            end
          end
        end
        trng_pkg::FILL: begin
          if (!fifo_empty && (|pick) && gnt_q == '0) begin
            pop     = 1'b1;
            gnt_d   = pick[NREQ-1:0];
            rdata_d = fifo_head;
            rr_d    = gidx;
          end
          if (!trng_run) begin
            state_d   = trng_pkg::IDLE;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end else if (qual) begin
            shreg_d = {shreg_q[WORD_W-2:0], trng_bit};
            if (bit_cnt_q == BCW'(WORD_W - 1)) begin
              bit_cnt_d = '0;
              if (!fifo_full || pop) push = 1'b1;
              else if (ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        trng_pkg::RESEED: begin
          if (!trng_run) state_d = trng_pkg::IDLE;
        end
        default: state_d = trng_pkg::IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trng_req_arbiter.sv
// Directed and randomized bench for trng_req_arbiter against a queue-based
// reference model of the word stream, grant order and overflow accounting.
module tb_trng_req_arbiter;

  localparam int NREQ       = 4;
  localparam int WORD_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DISCARD    = 4;

  localparam int M_IDLE = 0, M_WARM = 1, M_FILL = 2, M_RESEED = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       trng_run = 1'b0;
  logic       trng_bit_valid = 1'b0;
  logic       trng_bit = 1'b0;
  logic       reseed_req = 1'b0;
  logic       trng_restart;
  logic [2:0] fifo_level;
  logic [7:0] overflow_cnt;

  trng_req_arbiter_if #(.NREQ(NREQ), .WORD_W(WORD_W)) bus ();

  trng_req_arbiter #(
    .NREQ       (NREQ),
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DISCARD    (DISCARD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .trng_run       (trng_run),
    .trng_bit_valid (trng_bit_valid),
    .trng_bit       (trng_bit),
    .reseed_req     (reseed_req),
    .bus            (bus),
    .trng_restart   (trng_restart),
    .fifo_level     (fifo_level),
    .overflow_cnt   (overflow_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: warm-up countdown, bit accumulator, word queue.
  int         m_mode, m_warm, m_nbits, m_acc, m_last_rr, m_ovf;
  logic [7:0] m_q[$];
  bit         m_gnt_prev;
  int         e_gnt;
  int         e_rdata;
  bit         e_restart;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_warm = 0; m_nbits = 0; m_acc = 0;
    m_last_rr = 0; m_ovf = 0; m_gnt_prev = 0;
    m_q.delete();
  endtask

  task automatic model_cycle();
    bit qual, do_pop, accept;
    int idx, word;
    qual = trng_run & trng_bit_valid;
    e_gnt = 0; e_rdata = 0; e_restart = 0;
    do_pop = 0; idx = 0;
    if (reseed_req && m_mode != M_RESEED) begin
      m_mode = M_RESEED; m_q.delete(); m_nbits = 0; m_acc = 0; e_restart = 1;
    end else if (m_mode == M_IDLE) begin
      if (trng_run) begin m_mode = M_WARM; m_warm = DISCARD; end
    end else if (m_mode == M_WARM) begin
      if (!trng_run) m_mode = M_IDLE;
      else if (qual) begin
        m_warm--;
        if (m_warm == 0) m_mode = M_FILL;
      end
    end else if (m_mode == M_FILL) begin
      if (m_q.size() > 0 && bus.req != 0 && !m_gnt_prev) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last_rr + k) % NREQ;
          if (bus.req[idx]) break;
        end
        do_pop = 1; e_gnt = 1 << idx; e_rdata = m_q[0]; m_last_rr = idx;
      end
      accept = 0; word = 0;
      if (!trng_run) begin
        m_mode = M_IDLE; m_nbits = 0; m_acc = 0;
      end else if (qual) begin
        m_acc = (m_acc * 2 + int'(trng_bit)) % 256;
        m_nbits++;
        if (m_nbits == WORD_W) begin
          m_nbits = 0; word = m_acc;
          if (m_q.size() < FIFO_DEPTH || do_pop) accept = 1;
          else if (m_ovf < 255) m_ovf++;
        end
      end
      if (do_pop) void'(m_q.pop_front());
      if (accept) m_q.push_back(word[7:0]);
    end else begin
      if (!trng_run) m_mode = M_IDLE;
    end
    m_gnt_prev = (e_gnt != 0);
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    check("gnt", bus.gnt, e_gnt);
    if (e_gnt != 0) check("rdata", bus.rdata, e_rdata);
    check("restart", trng_restart, e_restart);
    check("level", fifo_level, m_q.size());
    check("ovf", overflow_cnt, m_ovf);
  endtask

  logic [11:0] pat;
  logic [3:0]  gnt_seq[8];
  logic [3:0]  held;
  logic [7:0]  first_word;
  int          ovf_before;

  initial begin
    bus.req = '0;
    model_reset();

    // Reset state
    @(posedge clk); #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_restart", trng_restart, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow_cnt, 0);
    rst = 1'b1;

    // Startup and discard: 4 dropped bits then 8'hA5
    trng_run = 1'b1; trng_bit_valid = 1'b0;
    step();
    pat = 12'b1111_1010_0101;
    trng_bit_valid = 1'b1;
    for (int i = 11; i >= 0; i--) begin
      trng_bit = pat[i];
      step();
    end
    check("t1_level", fifo_level, 1);

    // Fill to 4 words with random bits, then round-robin drain
    for (int i = 0; i < 3 * WORD_W; i++) begin
      trng_bit = 1'($urandom_range(0, 1));
      step();
    end
    check("t2_full", fifo_level, 4);
    trng_bit_valid = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      gnt_seq[i] = bus.gnt;
      if (i == 0) first_word = bus.rdata;
    end
    check("t1_word", first_word, 8'hA5);
    check("t2_g0", gnt_seq[0], 4'b0010);
    check("t2_g1", gnt_seq[1], 4'b0000);
    check("t2_g2", gnt_seq[2], 4'b0100);
    check("t2_g4", gnt_seq[4], 4'b1000);
    check("t2_g6", gnt_seq[6], 4'b0001);
    check("t2_empty", fifo_level, 0);
    for (int i = 0; i < 3; i++) step();
    bus.req = '0;

    // Overflow: words 5 and 6 dropped
    trng_bit_valid = 1'b1;
    for (int i = 0; i < 200 && m_ovf < 2; i++) begin
      trng_bit = 1'($urandom_range(0, 1));
      step();
    end
    check("t3_level", fifo_level, 4);
    check("t3_ovf2", overflow_cnt, 2);

    // Same-cycle push and pop on a full FIFO
    for (int i = 0; i < 20 && m_nbits != WORD_W - 1; i++) begin
      trng_bit = 1'($urandom_range(0, 1));
      step();
    end
    ovf_before = m_ovf;
    bus.req = 4'b0100;
    trng_bit = 1'($urandom_range(0, 1));
    step();
    check("t4_gnt", bus.gnt, 4'b0100);
    check("t4_level", fifo_level, 4);
    check("t4_ovf", overflow_cnt, ovf_before);
    bus.req = '0;

    // Overflow counter saturation
    for (int i = 0; i < 3000 && m_ovf < 255; i++) begin
      trng_bit = 1'($urandom_range(0, 1));
      step();
    end
    for (int i = 0; i < 10 * WORD_W; i++) begin
      trng_bit = 1'($urandom_range(0, 1));
      step();
    end
    check("t3_sat", overflow_cnt, 255);

    // Reseed mid-fill: level 3, 5 bits packed
    trng_bit_valid = 1'b0;
    bus.req = 4'b0001;
    step();
    bus.req = '0;
    trng_bit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      trng_bit = 1'($urandom_range(0, 1));
      step();
    end
    check("t5_level3", fifo_level, 3);
    reseed_req = 1'b1;
    step();
    check("t5_restart", trng_restart, 1);
    check("t5_flush", fifo_level, 0);
    reseed_req = 1'b0;
    bus.req = 4'b1111;
    step();
    check("t5_pulse", trng_restart, 0);
    for (int i = 0; i < 20; i++) begin
      trng_bit = 1'($urandom_range(0, 1));
      step();
    end
    trng_run = 1'b0;
    bus.req = '0;
    for (int i = 0; i < 2; i++) step();

    // Async reset in the cycle a grant is showing
    trng_run = 1'b1;
    for (int i = 0; i < 40 && m_q.size() < 1; i++) begin
      trng_bit = 1'($urandom_range(0, 1));
      step();
    end
    trng_bit_valid = 1'b0;
    bus.req = 4'b0100;
    step();
    check("t6_gnt", bus.gnt, 4'b0100);
    #2 rst = 1'b0;
    #1;
    check("t6_async_gnt", bus.gnt, 0);
    check("t6_async_level", fifo_level, 0);
    check("t6_async_restart", trng_restart, 0);
    model_reset();
    bus.req = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b1;
    trng_bit_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      trng_bit = 1'($urandom_range(0, 1));
      step();
    end
    bus.req = '0;

    // Randomized traffic with requesters that hold req until granted
    held = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 3) trng_run = ~trng_run;
      trng_bit_valid = ($urandom_range(0, 99) < 80);
      trng_bit       = 1'($urandom_range(0, 1));
      reseed_req     = ($urandom_range(0, 99) < 2);
      for (int r = 0; r < NREQ; r++) begin
        if (!held[r] && $urandom_range(0, 3) == 0) held[r] = 1'b1;
      end
      bus.req = held;
      step();
      held = held & ~bus.gnt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
